// File: rtl/mult_div_unit.sv
// Multicycle signed/unsigned multiply and divide engine producing HI/LO for the CPU.
// Latency: WIDTH+2 edges from start accept to done (1 edge for divide-by-zero).
// Backpressure: none; start is honoured only when idle, busy tells the control unit to stall.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   start/op    operation request (00 MULT, 01 MULTU, 10 DIV, 11 DIVU), sampled only when idle
//   a/b         operands, latched on the accept edge
//   busy        high from the accept edge until done rises
//   done/div0   one-cycle completion pulse; div0 flags DIV/DIVU with b == 0
//   hi/lo       product halves, or remainder/quotient; held until the next good result
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_mag_q, a_mag_d;   // multiplier / dividend, shifts into quotient
  logic [WIDTH-1:0]   b_mag_q, b_mag_d;   // multiplicand / divisor magnitude
  logic [WIDTH-1:0]   part_q, part_d;     // upper product half / partial remainder
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_res_q, neg_res_d;  // negate product / quotient
  logic               neg_rem_q, neg_rem_d;  // negate remainder (dividend sign)
  logic               dz_q, dz_d;            // operation in flight is a divide by zero
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               in_signed;
  logic               in_div;
  logic [WIDTH:0]     sum_mul;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_sub;
  logic               rem_ge;
  logic [2*WIDTH-1:0] prod_fix;

  assign in_signed = ~op[0];
  assign in_div    = op[1];

  // Multiply step: conditionally add the multiplicand into the upper half, then the
  // {carry, part, a_mag} chain shifts right by one.
  assign sum_mul = {1'b0, part_q} + (a_mag_q[0] ? {1'b0, b_mag_q} : {(WIDTH+1){1'b0}});

  // Divide step: partial remainder is always < divisor, so after the left shift it
  // needs one extra bit, and a successful subtract fits back into WIDTH bits.
  assign rem_sh  = {part_q, a_mag_q[WIDTH-1]};
  assign rem_ge  = rem_sh >= {1'b0, b_mag_q};
  assign rem_sub = rem_sh[WIDTH-1:0] - b_mag_q;

  assign prod_fix = (~op_q[0] & neg_res_q) ? -{part_q, a_mag_q} : {part_q, a_mag_q};

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_mag_d   = a_mag_q;
    b_mag_d   = b_mag_q;
    part_d    = part_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      ST_IDLE: begin
        // The done cycle is still the tail of the previous operation.
        if (start && !done_q) begin
          op_d      = op;
          a_mag_d   = (in_signed && a[WIDTH-1]) ? -a : a;
          b_mag_d   = (in_signed && b[WIDTH-1]) ? -b : b;
          neg_res_d = in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = in_signed & a[WIDTH-1];
          part_d    = '0;
          cnt_d     = CNT_W'(WIDTH);
          dz_d      = in_div && (b == '0);
          state_d   = (in_div && (b == '0)) ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q - 1'b1;
        if (op_q[1]) begin
          part_d  = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
          a_mag_d = {a_mag_q[WIDTH-2:0], rem_ge};
        end else begin
          part_d  = sum_mul[WIDTH:1];
          a_mag_d = {sum_mul[0], a_mag_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        // Unsigned ops have both sign flags clear, so they pass straight through.
        if (op_q[1]) begin
          lo_d = neg_res_q ? -a_mag_q : a_mag_q;
          hi_d = neg_rem_q ? -part_q : part_q;
        end else begin
          lo_d = prod_fix[WIDTH-1:0];
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered outputs: done/div0 are the registered image of the DONE state, and
    // busy drops on the same edge that raises done.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_DONE);
    div0_d = (state_q == ST_DONE) && dz_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      a_mag_q   <= '0;
      b_mag_q   <= '0;
      part_q    <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_mag_q   <= a_mag_d;
      b_mag_q   <= b_mag_d;
      part_q    <= part_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit at WIDTH=32: stimulus pushes reference results,
// an independent monitor pops and compares them whenever done pulses.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div0;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .div0  (div0),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           acc;
  } exp_t;

  exp_t         exp_q[$];
  int           cyc = 0;
  int           total = 0;
  int           passed = 0;
  int           busy_run = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  // Reference model: plain arithmetic on sign-extended 64-bit values; SV integer
  // division truncates toward zero and % takes the dividend's sign.
  task automatic model_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output exp_t e);
    longint          sx, sy, q, r;
    logic [63:0]     p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.dz = 1'b0;
    case (o)
      2'd0: begin p = sx * sy; m_hi = p[63:32]; m_lo = p[31:0]; end
      2'd1: begin p = {32'd0, x} * {32'd0, y}; m_hi = p[63:32]; m_lo = p[31:0]; end
      2'd2: begin
        if (y == '0) e.dz = 1'b1;
        else begin
          q = sx / sy; r = sx % sy;
          p = q; m_lo = p[31:0];
          p = r; m_hi = p[31:0];
        end
      end
      default: begin
        if (y == '0) e.dz = 1'b1;
        else begin m_lo = x / y; m_hi = x % y; end
      end
    endcase
    e.hi  = m_hi;
    e.lo  = m_lo;
    e.acc = 0;
  endtask

  // Called at posedge+1; waits for idle, drives one start pulse, records the accept edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int   n = 0;
    while ((busy || done) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) chk("idle_timeout", 64'(n), 64'(0));
    start = 1'b1; op = o; a = x; b = y;
    model_op(o, x, y, e);
    @(posedge clk); #1;
    e.acc = cyc;
    start = 1'b0;
    chk("busy_after_accept", 64'(busy), 64'(1));
    exp_q.push_back(e);
  endtask

  // Monitor: compares every done pulse against the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_done: got done=1 hi=0x%0h lo=0x%0h, expected no done", hi, lo);
        end else begin
          exp_t e;
          int   lat;
          e = exp_q.pop_front();
          lat = e.dz ? 1 : W + 2;
          chk("hi", 64'(hi), 64'(e.hi));
          chk("lo", 64'(lo), 64'(e.lo));
          chk("div0", 64'(div0), 64'(e.dz));
          chk("latency", 64'(cyc - e.acc), 64'(lat));
          chk("busy_cycles", 64'(busy_run), 64'(lat));
          chk("busy_at_done", 64'(busy), 64'(0));
        end
        busy_run = 0;
      end else begin
        if (div0) begin
          total++;
          $display("FAIL div0_without_done: got div0=1, expected 0");
        end
      end
    end
  end

  function automatic logic [W-1:0] pick(input int sel);
    logic [W-1:0] v;
    case (sel)
      0: v = 32'h8000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h0000_0000;
      3: v = 32'h0000_0001;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    exp_t e;
    int   n;
    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_div0", 64'(div0), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    reset = 1'b1;
    @(posedge clk); #1;

    issue(2'd0, 32'hFFFF_FFFE, 32'h0000_0003);
    issue(2'd1, 32'hFFFF_FFFE, 32'h0000_0003);
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    issue(2'd3, 32'h0000_0007, 32'h0000_0002);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'd0, 32'h0000_0005, 32'h0000_0006);
    issue(2'd3, 32'h0000_0007, 32'h0000_0000);
    issue(2'd2, 32'h0000_0064, 32'hFFFF_FFF9);

    // Starts while busy are ignored; start in the done cycle is ignored, and the
    // same start held into the first idle cycle is accepted.
    issue(2'd0, 32'h0000_0003, 32'h0000_0004);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      start = 1'($urandom_range(0, 1)); op = 2'($urandom); a = $urandom; b = $urandom;
    end
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("done_timeout", 64'(n), 64'(0));
    start = 1'b1; op = 2'd1; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    chk("start_in_done_ignored", 64'(busy), 64'(0));
    model_op(2'd1, 32'd9, 32'd9, e);
    @(posedge clk); #1;
    e.acc = cyc;
    start = 1'b0;
    chk("start_first_idle_accepted", 64'(busy), 64'(1));
    exp_q.push_back(e);

    // Reset pulse in the middle of a divide.
    issue(2'd2, 32'h1234_5678, 32'h0000_0013);
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_div0", 64'(div0), 64'(0));
    chk("midrst_hi", 64'(hi), 64'(0));
    chk("midrst_lo", 64'(lo), 64'(0));
    exp_q.delete();
    m_hi = '0;
    m_lo = '0;
    @(posedge clk); #3;
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    issue(2'd3, 32'h0000_0007, 32'h0000_0000);
    issue(2'd1, 32'h0001_0000, 32'h0001_0000);

    for (int i = 0; i < 60; i++) begin
      issue(2'($urandom_range(0, 3)), pick($urandom_range(0, 9)), pick($urandom_range(0, 9)));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised multicycle multiply/divide engine that produces the HI/LO results for the multicycle CPU.
- Supports signed and unsigned multiply and divide at any operand width.
- The control unit pulses start and stalls on busy; done serves as the HI/LO write enable.
- Adds unsigned modes, divide-by-zero detection and a busy/done handshake.

Parameters:
WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; must be >= 4.
CNT_W, $clog2(WIDTH+1), width of the iteration counter; derived, do not override.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset; clears all state immediately.
start  input  1  request a new operation; sampled only in IDLE.
op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
a  input  WIDTH  multiplicand or dividend; sampled with start.
b  input  WIDTH  multiplier or divisor; sampled with start.
busy  output  1  high from the start-accept edge until the edge on which done rises.
done  output  1  one-cycle pulse; hi/lo are valid, or div0 is set.
div0  output  1  one-cycle pulse coincident with done when DIV/DIVU has b == 0.
hi  output  WIDTH  MULT: upper product half; DIV: remainder.
lo  output  WIDTH  MULT: lower product half; DIV: quotient.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- While reset is low, in any state: FSM=IDLE, busy=0, done=0, div0=0, hi=0, lo=0, counter=0, operand and partial registers=0.
- A reset asserted mid-operation aborts it with no done pulse.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE, start=1 at edge E0:
  - Latch op.
  - For signed ops, latch |a| and |b| as unsigned magnitudes and record result signs. For unsigned ops, latch a and b directly.
  - Clear the partial register; counter=WIDTH; busy=1.
  - If op is DIV/DIVU and b==0, go to DONE; otherwise go to CALC.
- CALC: one radix-2 iteration per cycle, counter decrements; leave for FIX when the counter reaches 0, i.e. after exactly WIDTH cycles.
  - Multiply: shift-add on the magnitude registers into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder magnitudes.
- FIX, one cycle:
  - Signed multiply: negate the 2*WIDTH product if sign(a) XOR sign(b).
  - Signed divide: negate the quotient if sign(a) XOR sign(b); negate the remainder if sign(a). This truncates toward zero and gives the remainder the dividend's sign.
  - Load hi/lo on the FIX->DONE edge.
  - Unsigned ops pass through FIX unchanged, so latency is uniform.
- DONE, one cycle:
  - done=1 and busy=0; next state IDLE.
  - On the div-by-zero path, div0=1 and hi/lo keep their previous values.
- Latency:
  - Normal ops: start sampled at E0; done high during the cycle after edge E0+WIDTH+2 (WIDTH=32: edge 34).
  - Div-by-zero: done and div0 high after edge E0+1.
- start outside IDLE is ignored. Any start/op/a/b changes while busy do not affect the operation in flight.
- start in the DONE cycle is also ignored; a new op may be accepted on the first IDLE cycle, so back-to-back ops have a 1-cycle gap.
- hi/lo hold their last results until the next completed, non-div0 operation.
- Overflow cases wrap with no flag. Signed DIV of most-negative / -1 gives lo = most-negative value, hi = 0. The full 2*WIDTH product never overflows.
- The most-negative operand in signed mode has magnitude 2^(WIDTH-1) and must be handled exactly. The magnitude registers are WIDTH bits unsigned.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- WIDTH=32, MULT a=0xFFFFFFFE b=0x00000003 -> after 34 edges done=1 for one cycle, hi=0xFFFFFFFF, lo=0xFFFFFFFA, div0=0; busy high for the preceding 34 cycles.
- MULTU a=0xFFFFFFFE b=0x00000003 -> hi=0x00000002, lo=0xFFFFFFFA; MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload hi/lo via MULT 5*6 (hi=0, lo=30), then DIVU a=7 b=0 -> done=div0=1 one cycle after start edge; hi=0, lo=30 unchanged; next op runs normally.
- Pulse start repeatedly with different a/b while busy during a MULT 3*4 -> result hi=0, lo=12; extra starts have no effect; a start in the first IDLE cycle after done is accepted.
- Drop reset low for one cycle at cycle 10 of a DIV -> hi=lo=0, busy=done=div0=0 immediately (asynchronously); no done pulse; the unit accepts a new start after reset is released.
